// File: rtl/clusterv_wb_sram_bridge.sv
// -----------------------------------------------------------------------------
// clusterv_wb_sram_bridge
//
// Purpose: Wishbone target that maps a word-addressed SRAM into a byte-address
// window starting at BASE_ADDR. Writes complete in one cycle (ack the cycle
// after the request). Reads wait one cycle for the SRAM data before acking.
// Misaligned or out-of-window accesses get err instead of ack and never
// strobe the SRAM.
//
// Ports:
//   clock         single clock, rising edge
//   reset         asynchronous, active-low reset
//   adr_i         Wishbone byte address
//   dat_w         Wishbone write data
//   dat_r         Wishbone read data (holds the last completed read)
//   cyc, stb, we  Wishbone cycle, strobe and write-enable
//   sel           Wishbone byte selects
//   ack, err      Wishbone termination
//   i_addr        SRAM word address
//   i_write_data  SRAM write data
//   i_read_data   SRAM read data, valid the cycle after i_read_en
//   i_read_en     SRAM read strobe
//   i_write_en    SRAM write strobe
//   i_byte_en     SRAM byte enables
// -----------------------------------------------------------------------------
module clusterv_wb_sram_bridge #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          adr_i,
  input  logic [31:0]          dat_w,
  output logic [31:0]          dat_r,
  input  logic                 cyc,
  input  logic                 stb,
  input  logic                 we,
  input  logic [3:0]           sel,
  output logic                 ack,
  output logic                 err,
  output logic [ADDR_BITS-1:0] i_addr,
  output logic [31:0]          i_write_data,
  input  logic [31:0]          i_read_data,
  output logic                 i_read_en,
  output logic                 i_write_en,
  output logic [3:0]           i_byte_en
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;

  logic [1:0]  r_state;
  logic        r_err;
  logic [31:0] r_dat_r;

  logic w_request;
  logic w_bad;
  logic w_in_resp;

  // Gating with reset keeps the SRAM strobes low while reset is held, even
  // though the state register already sits in IDLE.
  assign w_request = reset & (r_state == S_IDLE) & cyc & stb;

  assign w_bad = (adr_i[1:0] != 2'b00) |
                 (adr_i[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2]);

  assign i_addr       = adr_i[ADDR_BITS+1:2];
  assign i_write_data = dat_w;
  assign i_byte_en    = sel;

  assign i_write_en = w_request &  we & ~w_bad;
  assign i_read_en  = w_request & ~we & ~w_bad;

  // Termination is qualified by cyc so a master that gives up in the
  // response cycle never sees a stray ack/err.
  assign w_in_resp = (r_state == S_RESP) & cyc;
  assign ack       = w_in_resp & ~r_err;
  assign err       = w_in_resp &  r_err;

  assign dat_r = r_dat_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_dat_r <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_request) begin
            if (w_bad) begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
            end else if (we) begin
              r_state <= S_RESP;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_RD_WAIT;
              r_err   <= 1'b0;
            end
          end
        end
        S_RD_WAIT: begin
          // Dropping cyc while the SRAM read is in flight abandons it;
          // dat_r keeps the previous completed value.
          if (cyc) begin
            r_dat_r <= i_read_data;
            r_state <= S_RESP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clusterv_wb_sram_bridge.sv
module tb_clusterv_wb_sram_bridge;

  localparam int          AB   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          WIN  = 4 << AB;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   adr_i = '0;
  logic [31:0]   dat_w = '0;
  logic [31:0]   dat_r;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    sel = '0;
  logic          ack;
  logic          err;
  logic [AB-1:0] i_addr;
  logic [31:0]   i_write_data;
  logic [31:0]   i_read_data;
  logic          i_read_en;
  logic          i_write_en;
  logic [3:0]    i_byte_en;

  int total = 0;
  int bad   = 0;

  clusterv_wb_sram_bridge #(.ADDR_BITS(AB), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .adr_i(adr_i), .dat_w(dat_w), .dat_r(dat_r),
    .cyc(cyc), .stb(stb), .we(we), .sel(sel), .ack(ack), .err(err),
    .i_addr(i_addr), .i_write_data(i_write_data), .i_read_data(i_read_data),
    .i_read_en(i_read_en), .i_write_en(i_write_en), .i_byte_en(i_byte_en)
  );

  always #5 clock = ~clock;

  // SRAM device: byte-enabled writes, read data registered one cycle later.
  logic [31:0] sram [0:(1<<AB)-1];
  logic [31:0] sram_q = '0;
  initial for (int i = 0; i < (1<<AB); i++) sram[i] = '0;
  always @(posedge clock) begin
    if (i_write_en)
      for (int b = 0; b < 4; b++)
        if (i_byte_en[b]) sram[i_addr][8*b +: 8] <= i_write_data[8*b +: 8];
    if (i_read_en) sram_q <= sram[i_addr];
  end
  assign i_read_data = sram_q;

  // Reference model: flat byte image of the window plus the expected dat_r.
  logic [7:0]  exp_b [0:WIN-1];
  logic [31:0] exp_dat = '0;
  initial for (int i = 0; i < WIN; i++) exp_b[i] = '0;

  function automatic logic is_good(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && ((a - BASE) < WIN);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int o;
    o = int'(a - BASE);
    return {exp_b[o+3], exp_b[o+2], exp_b[o+1], exp_b[o]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag);
    logic g;
    logic [AB-1:0] wa;
    g  = is_good(a);
    wa = AB'((a - BASE) >> 2);
    cyc = 1'b1; stb = 1'b1; we = w; adr_i = a; dat_w = d; sel = s;
    #1;
    total++;
    if (i_write_en !== (w & g) || i_read_en !== (!w & g)) begin
      bad++;
      $display("FAIL %s strobe wr=%0b rd=%0b want wr=%0b rd=%0b", tag, i_write_en, i_read_en, w & g, !w & g);
    end
    total++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s req_cycle ack=%0b err=%0b want 0 0", tag, ack, err);
    end
    if (g) begin
      total++;
      if (i_addr !== wa || i_byte_en !== s || (w && i_write_data !== d)) begin
        bad++;
        $display("FAIL %s sram_bus addr=%0h be=%0h wd=%h want addr=%0h be=%0h wd=%h",
                 tag, i_addr, i_byte_en, i_write_data, wa, s, d);
      end
    end
    if (g && w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_b[int'(a - BASE) + b] = d[8*b +: 8];
      tick();
      total++;
      if (ack !== 1'b1 || err !== 1'b0) begin
        bad++;
        $display("FAIL %s write_ack ack=%0b err=%0b want 1 0", tag, ack, err);
      end
    end else if (g) begin
      tick();
      total++;
      if (ack !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL %s rd_wait ack=%0b err=%0b want 0 0", tag, ack, err);
      end
      tick();
      exp_dat = model_word(a);
      total++;
      if (ack !== 1'b1 || err !== 1'b0 || dat_r !== exp_dat) begin
        bad++;
        $display("FAIL %s read_ack ack=%0b err=%0b dat_r=%h want 1 0 %h", tag, ack, err, dat_r, exp_dat);
      end
    end else begin
      tick();
      total++;
      if (err !== 1'b1 || ack !== 1'b0 || dat_r !== exp_dat) begin
        bad++;
        $display("FAIL %s bad_req err=%0b ack=%0b dat_r=%h want 1 0 %h", tag, err, ack, dat_r, exp_dat);
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr_i = 32'h10;
    repeat (2) tick();
    total++;
    if (ack !== 1'b0 || err !== 1'b0 || i_read_en !== 1'b0 || i_write_en !== 1'b0 || dat_r !== 32'h0) begin
      bad++;
      $display("FAIL reset_state ack=%0b err=%0b rd=%0b wr=%0b dat_r=%h want all 0",
               ack, err, i_read_en, i_write_en, dat_r);
    end
    cyc = 1'b0; stb = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, "wr_deadbeef");
    do_txn(1'b0, 32'h0000_0010, 32'h0,         4'hF, "rd_deadbeef");
    do_txn(1'b1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, "wr_byte1");
    do_txn(1'b0, 32'h0000_0010, 32'h0,         4'hF, "rd_merged");
    do_txn(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, "wr_sel0");
    do_txn(1'b0, 32'h0000_0020, 32'h0,         4'hF, "rd_sel0");
  endtask

  task automatic test_errors();
    do_txn(1'b0, 32'h0000_0010, 32'h0,         4'hF, "rd_before_err");
    do_txn(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, "wr_out_window");
    do_txn(1'b0, 32'h0000_1000, 32'h0,         4'hF, "rd_out_window");
    do_txn(1'b0, 32'h0000_0012, 32'h0,         4'hF, "rd_misaligned");
    do_txn(1'b1, 32'h8000_0004, 32'h1,         4'hF, "wr_high_addr");
    do_txn(1'b0, 32'h0000_0010, 32'h0,         4'hF, "rd_after_err");
  endtask

  task automatic test_resp_drop();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr_i = 32'h30; dat_w = 32'hCAFE_F00D; sel = 4'hF;
    for (int b = 0; b < 4; b++) exp_b[int'(32'h30 - BASE) + b] = dat_w[8*b +: 8];
    tick();
    cyc = 1'b0; stb = 1'b0;
    #1;
    total++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL resp_drop_wr ack=%0b err=%0b want 0 0", ack, err);
    end
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr_i = 32'h31;
    tick();
    cyc = 1'b0; stb = 1'b0;
    #1;
    total++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL resp_drop_err ack=%0b err=%0b want 0 0", ack, err);
    end
    tick();
    do_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, "rd_after_drop");
  endtask

  task automatic test_abort();
    do_txn(1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF, "wr_abort_tgt");
    do_txn(1'b0, 32'h0000_0010, 32'h0,         4'hF, "rd_abort_pre");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr_i = 32'h40;
    tick();
    cyc = 1'b0; stb = 1'b0;
    #1;
    total++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL abort_wait ack=%0b err=%0b want 0 0", ack, err);
    end
    tick();
    total++;
    if (ack !== 1'b0 || err !== 1'b0 || dat_r !== exp_dat) begin
      bad++;
      $display("FAIL abort_hold ack=%0b err=%0b dat_r=%h want 0 0 %h", ack, err, dat_r, exp_dat);
    end
    do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, "rd_after_abort");
  endtask

  task automatic test_reset_mid();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr_i = 32'h10; sel = 4'hF;
    tick();
    #2;
    reset = 1'b0;
    #1;
    exp_dat = 32'h0;
    total++;
    if (ack !== 1'b0 || err !== 1'b0 || i_read_en !== 1'b0 || i_write_en !== 1'b0 || dat_r !== exp_dat) begin
      bad++;
      $display("FAIL reset_mid ack=%0b err=%0b rd=%0b wr=%0b dat_r=%h want 0 0 0 0 0",
               ack, err, i_read_en, i_write_en, dat_r);
    end
    reset = 1'b1;
    we = 1'b1; adr_i = 32'h50; dat_w = 32'h1234_5678; sel = 4'hF;
    #1;
    total++;
    if (i_write_en !== 1'b1 || ack !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_req wr=%0b ack=%0b want 1 0", i_write_en, ack);
    end
    for (int b = 0; b < 4; b++) exp_b[int'(32'h50 - BASE) + b] = dat_w[8*b +: 8];
    tick();
    total++;
    if (ack !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_ack ack=%0b err=%0b want 1 0", ack, err);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    do_txn(1'b0, 32'h0000_0050, 32'h0, 4'hF, "rd_post_reset");
  endtask

  task automatic test_back_to_back();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr_i = 32'h60; dat_w = 32'hA5A5_0001; sel = 4'hF;
    for (int b = 0; b < 4; b++) exp_b[int'(32'h60 - BASE) + b] = dat_w[8*b +: 8];
    tick();
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ack1 ack=%0b want 1", ack);
    end
    adr_i = 32'h64; dat_w = 32'h5A5A_0002;
    #1;
    total++;
    if (i_write_en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_resp_strobe wr=%0b want 0", i_write_en);
    end
    tick();
    total++;
    if (i_write_en !== 1'b1 || i_addr !== AB'(32'h64 >> 2) || ack !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_req wr=%0b addr=%0h ack=%0b want 1 19 0", i_write_en, i_addr, ack);
    end
    for (int b = 0; b < 4; b++) exp_b[int'(32'h64 - BASE) + b] = dat_w[8*b +: 8];
    tick();
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ack2 ack=%0b want 1", ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    do_txn(1'b0, 32'h0000_0060, 32'h0, 4'hF, "rd_b2b_a");
    do_txn(1'b0, 32'h0000_0064, 32'h0, 4'hF, "rd_b2b_b");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        w;
    for (int n = 0; n < 60; n++) begin
      a = BASE + {20'h0, 4'($urandom_range(0, 3)), 6'($urandom), 2'b00};
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a = a + WIN;
      w = 1'($urandom);
      do_txn(w, a, $urandom, 4'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_resp_drop();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
